// File: rtl/mem_port_arbiter_if.sv
// Line-port bundle between requesters, the arbiter and RAM port A.
// The arbiter takes the slave side; requesters/RAM take the master side.
interface mem_port_arbiter_if #(
  parameter int CNT_W = 32
) ();
  logic [2:0]         req_valid;
  logic [2:0]         req_ready;
  logic [95:0]        req_addr;
  logic [2:0]         req_wen;
  logic [383:0]       req_wdata;
  logic [2:0]         resp_valid;
  logic [127:0]       resp_rdata;
  logic               resp_err;
  logic [31:0]        ram_addr;
  logic [127:0]       ram_din;
  logic               ram_we;
  logic [127:0]       ram_dout;
  logic [3*CNT_W-1:0] grant_cnt;

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, ram_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_addr, ram_din, ram_we, grant_cnt
  );

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, ram_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_addr, ram_din, ram_we, grant_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way line-port arbiter with fixed memory latency, one access
// outstanding; ids 0/1 round-robin, id 2 only when both are idle.
module mem_port_arbiter #(
  parameter int LATENCY = 8,
  parameter int CNT_W   = 32
) (
  input logic clock,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t                    r_state;
  logic [1:0]                r_id;
  logic [31:0]               r_addr;
  logic                      r_wen;
  logic                      r_err;
  logic [127:0]              r_wdata;
  logic [7:0]                r_cnt;
  logic                      r_rr_last;
  logic [2:0]                r_resp_valid;
  logic [127:0]              r_resp_rdata;
  logic                      r_resp_err;
  logic                      r_ram_we;
  logic [31:0]               r_ram_addr;
  logic [127:0]              r_ram_din;
  logic [2:0][CNT_W-1:0]     r_gcnt;

  logic [2:0]  w_grant;
  logic [1:0]  w_gid;
  logic [31:0] w_addr;
  logic        w_open;

  // Both 0 and 1 pending: hand the port to whichever did not win last.
  always_comb begin
    w_grant = 3'b000;
    if (bus.req_valid[0] && bus.req_valid[1])
      w_grant = r_rr_last ? 3'b001 : 3'b010;
    else if (bus.req_valid[0])
      w_grant = 3'b001;
    else if (bus.req_valid[1])
      w_grant = 3'b010;
    else if (bus.req_valid[2])
      w_grant = 3'b100;
  end

  assign w_gid  = w_grant[2] ? 2'd2 : (w_grant[1] ? 2'd1 : 2'd0);
  assign w_addr = bus.req_addr[32*w_gid +: 32] & ~32'hF;
  assign w_open = (r_state == IDLE) && !reset;

  assign bus.req_ready  = w_open ? w_grant : 3'b000;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_din    = r_ram_din;
  assign bus.ram_we     = r_ram_we;
  assign bus.grant_cnt  = r_gcnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_id         <= 2'd0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_err        <= 1'b0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_rr_last    <= 1'b0;
      r_resp_valid <= 3'b000;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_gcnt       <= '0;
    end else begin
      r_ram_we     <= 1'b0;
      r_resp_valid <= 3'b000;
      r_resp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_id    <= w_gid;
            r_addr  <= w_addr;
            r_err   <= |w_addr[30:14];
            r_wen   <= bus.req_wen[w_gid];
            r_wdata <= bus.req_wdata[128*w_gid +: 128];
            r_cnt   <= LAT_M1;
            if (!w_grant[2])
              r_rr_last <= w_grant[0] ? 1'b0 : 1'b1;
            r_gcnt[w_gid] <= r_gcnt[w_gid] + CNT_W'(1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 8'd0) begin
            r_ram_addr <= r_addr;
            if (r_wen && !r_err) begin
              r_ram_we  <= 1'b1;
              r_ram_din <= r_wdata;
            end
            r_state <= ACCESS;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ACCESS: begin
          r_resp_rdata <= (r_wen || r_err) ? '0 : bus.ram_dout;
          r_resp_valid <= 3'b001 << r_id;
          r_resp_err   <= r_err;
          r_state      <= RESP;
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timing model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;
  localparam int L  = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.CNT_W(CW)) bus ();

  mem_port_arbiter #(.LATENCY(L), .CNT_W(CW)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  function automatic logic [127:0] seedline(int i);
    logic [31:0] x;
    x = 32'(i);
    if (i == 16) return 128'h0123456789abcdef_fedcba9876543210;
    return {x * 32'h9E3779B9, x ^ 32'h5A5A0000, ~x, x * 32'h01000193};
  endfunction

  logic [127:0] ram [1024];
  logic [127:0] emem [1024];

  assign bus.ram_dout = ram[bus.ram_addr[13:4]];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 1024; i++) ram[i] <= seedline(i);
    end else if (bus.ram_we) begin
      ram[bus.ram_addr[13:4]] <= bus.ram_din;
    end
  end

  int          we_cycles = 0;
  int          resp_cnt = 0;
  logic [31:0] last_we_addr = '0;
  logic [2:0]  rdy_seen = '0;

  always @(negedge clk) begin
    rdy_seen <= bus.req_ready;
    if (bus.ram_we === 1'b1) begin
      we_cycles    <= we_cycles + 1;
      last_we_addr <= bus.ram_addr;
    end
    if (bus.resp_valid !== 3'b000) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] pick(logic [2:0] v, int rr);
    if (v[0] && v[1]) return (rr == 0) ? 3'b010 : 3'b001;
    if (v[0]) return 3'b001;
    if (v[1]) return 3'b010;
    if (v[2]) return 3'b100;
    return 3'b000;
  endfunction

  // Reference: each accept at cycle c fixes access at c+L+1,
  // response at c+L+2 and the next open slot at c+L+3.
  initial begin
    longint       m_acc, m_resp, m_free, c;
    int           rr, m_id;
    logic [31:0]  m_addr, m_raddr;
    logic         m_wen, m_err, e_we;
    logic [127:0] m_wdata, m_rdin, m_rdata;
    logic [31:0]  gc [3];
    logic [2:0]   e_rdy, e_rv;
    logic [31:0]  a;
    m_acc = -1; m_resp = -1; m_free = 0; rr = 0; m_id = 0;
    m_addr = '0; m_raddr = '0; m_wen = 0; m_err = 0;
    m_wdata = '0; m_rdin = '0; m_rdata = '0;
    for (int i = 0; i < 3; i++) gc[i] = '0;
    for (int i = 0; i < 1024; i++) emem[i] = seedline(i);
    forever begin
      @(negedge clk);
      c = longint'(cyc);
      if (rst) begin
        m_acc = -1; m_resp = -1; m_free = 0; rr = 0;
        m_raddr = '0; m_rdin = '0; m_rdata = '0;
        for (int i = 0; i < 3; i++) gc[i] = '0;
      end
      e_rdy = 3'b000;
      e_we  = 1'b0;
      e_rv  = 3'b000;
      if (!rst && c >= m_free) e_rdy = pick(bus.req_valid, rr);
      if (!rst && c == m_acc) begin
        m_raddr = m_addr;
        if (m_wen && !m_err) begin
          e_we   = 1'b1;
          m_rdin = m_wdata;
        end
        m_rdata = (m_wen || m_err) ? '0 : emem[m_addr[13:4]];
      end
      if (!rst && c == m_resp) e_rv = 3'(1 << m_id);
      chk("req_ready", 128'(bus.req_ready), 128'(e_rdy));
      chk("ram_we", 128'(bus.ram_we), 128'(e_we));
      chk("ram_addr", 128'(bus.ram_addr), 128'(m_raddr));
      chk("ram_din", bus.ram_din, m_rdin);
      chk("resp_valid", 128'(bus.resp_valid), 128'(e_rv));
      chk("grant_cnt", 128'(bus.grant_cnt), 128'({gc[2], gc[1], gc[0]}));
      if (e_rv != 3'b000 || rst) begin
        chk("resp_rdata", bus.resp_rdata, (e_rv != 0) ? m_rdata : '0);
        chk("resp_err", 128'(bus.resp_err), (e_rv != 0) ? 128'(m_err) : '0);
      end
      if (e_we) emem[m_addr[13:4]] = m_wdata;
      if (e_rdy != 3'b000) begin
        m_id    = e_rdy[2] ? 2 : (e_rdy[1] ? 1 : 0);
        a       = bus.req_addr[32*m_id +: 32];
        m_addr  = {a[31:4], 4'h0};
        m_err   = |m_addr[30:14];
        m_wen   = bus.req_wen[m_id];
        m_wdata = bus.req_wdata[128*m_id +: 128];
        if (m_id < 2) rr = m_id;
        gc[m_id] = gc[m_id] + 32'd1;
        m_acc  = c + L + 1;
        m_resp = c + L + 2;
        m_free = c + L + 3;
      end
    end
  end

  task automatic set_req(int id, logic [31:0] a, logic w, logic [127:0] d);
    bus.req_addr[32*id +: 32]   = a;
    bus.req_wen[id]             = w;
    bus.req_wdata[128*id +: 128] = d;
    bus.req_valid[id]           = 1'b1;
  endtask

  task automatic wait_grant(output int g, output int t);
    g = -1;
    t = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.req_ready != 3'b000) begin
        g = bus.req_ready[2] ? 2 : (bus.req_ready[1] ? 1 : 0);
        t = cyc;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL grant_timeout cyc=%0d got=none want=grant", cyc);
  endtask

  task automatic wait_resp(output logic [2:0] v, output logic [127:0] d,
                           output logic e, output int t);
    v = '0;
    d = '0;
    e = 1'b0;
    t = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.resp_valid != 3'b000) begin
        v = bus.resp_valid;
        d = bus.resp_rdata;
        e = bus.resp_err;
        t = cyc;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL resp_timeout cyc=%0d got=none want=resp", cyc);
  endtask

  task automatic issue(int id, logic [31:0] a, logic w, logic [127:0] d,
                       output int t);
    int g;
    set_req(id, a, w, d);
    wait_grant(g, t);
    chk("issue_id", 128'(g), 128'(id));
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic at_neg(int target);
    do @(negedge clk); while (cyc < target);
  endtask

  initial begin
    int           g, t, tp, tr, w0, r0;
    int           rr_exp [4];
    logic [2:0]   v;
    logic [127:0] d;
    logic         e;
    rr_exp = '{1, 0, 1, 0};
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_wen   = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_gated", 128'(bus.req_ready), 128'(0));
    rst = 1'b0;

    set_req(0, 32'h40, 1'b0, '0);
    set_req(1, 32'h80, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, t);
      chk("rr_order", 128'(g), 128'(rr_exp[k]));
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    wait_resp(v, d, e, tr);
    chk("rr_cnt0", 128'(bus.grant_cnt[31:0]), 128'(2));
    chk("rr_cnt1", 128'(bus.grant_cnt[63:32]), 128'(2));
    @(posedge clk);
    #1;

    issue(0, 32'h100, 1'b0, '0, t);
    at_neg(t + 9);
    chk("rd_addr_t9", 128'(bus.ram_addr), 128'(32'h100));
    at_neg(t + 10);
    chk("rd_valid_t10", 128'(bus.resp_valid), 128'(3'b001));
    chk("rd_line", bus.resp_rdata, 128'h0123456789abcdef_fedcba9876543210);
    chk("rd_err", 128'(bus.resp_err), 128'(0));
    @(posedge clk);
    #1;

    set_req(2, 32'h300, 1'b0, '0);
    set_req(0, 32'h140, 1'b0, '0);
    tp = 0;
    for (int k = 0; k < 3; k++) begin
      wait_grant(g, t);
      chk("starve_id", 128'(g), 128'(0));
      tp = t;
      @(posedge clk);
      #1;
      if (k == 2) bus.req_valid[0] = 1'b0;
    end
    wait_grant(g, t);
    chk("p2_id", 128'(g), 128'(2));
    chk("p2_slot", 128'(t - tp), 128'(11));
    @(posedge clk);
    #1;
    bus.req_valid[2] = 1'b0;
    wait_resp(v, d, e, tr);
    @(posedge clk);
    #1;

    w0 = we_cycles;
    issue(1, 32'h20F, 1'b1, {16{8'hA5}}, t);
    wait_resp(v, d, e, tr);
    chk("wr_we_pulses", 128'(we_cycles - w0), 128'(1));
    chk("wr_ram_addr", 128'(last_we_addr), 128'(32'h200));
    chk("wr_ack_v", 128'(v), 128'(3'b010));
    chk("wr_ack_rdata", d, 128'(0));
    @(posedge clk);
    #1;
    issue(0, 32'h200, 1'b0, '0, t);
    wait_resp(v, d, e, tr);
    chk("rb_rdata", d, {16{8'hA5}});
    @(posedge clk);
    #1;

    w0 = we_cycles;
    issue(0, 32'h0001_0000, 1'b1, {4{32'hDEAD_BEEF}}, t);
    wait_resp(v, d, e, tr);
    chk("oor_wr_we", 128'(we_cycles - w0), 128'(0));
    chk("oor_wr_err", 128'(e), 128'(1));
    @(posedge clk);
    #1;
    issue(0, 32'h0001_0000, 1'b0, '0, t);
    wait_resp(v, d, e, tr);
    chk("oor_rd_data", d, 128'(0));
    chk("oor_rd_err", 128'(e), 128'(1));
    @(posedge clk);
    #1;

    issue(2, 32'h180, 1'b0, '0, t);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    w0 = we_cycles;
    r0 = resp_cnt;
    @(negedge clk);
    chk("arst_rv", 128'(bus.resp_valid), 128'(0));
    chk("arst_addr", 128'(bus.ram_addr), 128'(0));
    chk("arst_gcnt", 128'(bus.grant_cnt), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (L + 4) @(negedge clk);
    chk("arst_no_we", 128'(we_cycles - w0), 128'(0));
    chk("arst_no_resp", 128'(resp_cnt - r0), 128'(0));
    @(posedge clk);
    #1;
    issue(1, 32'h200, 1'b0, '0, t);
    wait_resp(v, d, e, tr);
    chk("post_rst_lat", 128'(tr - t), 128'(L + 2));
    chk("post_rst_data", d, {16{8'hA5}});
    @(posedge clk);
    #1;

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (bus.req_valid[i] && rdy_seen[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_req(i,
                  ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FFF),
                  1'($urandom_range(0, 1)),
                  {$urandom, $urandom, $urandom, $urandom});
        end
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end
endmodule
